// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: opcodes, sequencer states, default width.
package cpu_pkg;

  localparam int unsigned CpuWidth = 16;
  localparam int unsigned OpWidth  = 4;

  typedef logic [OpWidth-1:0] opcode_t;

  localparam opcode_t OpAdd    = 4'd0;
  localparam opcode_t OpAnd    = 4'd1;
  localparam opcode_t OpXor    = 4'd2;
  localparam opcode_t OpOr     = 4'd3;
  localparam opcode_t OpSl     = 4'd4;
  localparam opcode_t OpSr     = 4'd5;
  localparam opcode_t OpMove   = 4'd6;
  localparam opcode_t OpImm    = 4'd7;
  localparam opcode_t OpIfjump = 4'd8;
  localparam opcode_t OpStore  = 4'd9;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StData,
    StExec,
    StTrap
  } state_e;

endpackage

// File: rtl/cpu_decode.sv
// Opcode classifier: splits the 4-bit opcode into the instruction classes the sequencer needs.
module cpu_decode
  import cpu_pkg::*;
(
  input  opcode_t op_i,
  output logic    is_load_o,
  output logic    is_store_o,
  output logic    is_imm_o,
  output logic    is_jump_o,
  output logic    is_illegal_o
);

  // Classify opcode; everything above STORE is an illegal-opcode trap.
  always_comb begin
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_imm_o     = 1'b0;
    is_jump_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (op_i)
      OpAdd, OpAnd, OpXor, OpOr, OpSl, OpSr, OpMove: is_load_o  = 1'b1;
      OpImm:                                         is_imm_o   = 1'b1;
      OpIfjump:                                      is_jump_o  = 1'b1;
      OpStore:                                       is_store_o = 1'b1;
      default:                                       is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the accumulator CPU. Owns PC, IR and the memory data register,
// and time-shares one single-port memory between instruction fetch and data access.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned   N        = CpuWidth,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run_en,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack,
  input  logic [N-1:0] acc_in,
  input  logic [N-1:0] offset_in,
  output logic [3:0]   alu_op,
  output logic [N-1:0] alu_b,
  output logic         acc_we,
  output logic [N-1:0] pc,
  output logic         retired,
  output logic         illegal
);

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] ir_q, ir_d;
  logic [N-1:0] mdr_q, mdr_d;
  logic         illegal_q, illegal_d;

  opcode_t      op;
  logic [N-1:0] imm_ext;
  logic [N-1:0] pc_inc;
  logic [N-1:0] data_addr;
  state_e       retire_state;

  logic is_load, is_store, is_imm, is_jump, is_illegal;

  assign op           = ir_q[N-1:N-OpWidth];
  assign imm_ext      = {{OpWidth{1'b0}}, ir_q[N-OpWidth-1:0]};
  assign pc_inc       = pc_q + N'(1);
  // Offset addition wraps naturally at N bits.
  assign data_addr    = imm_ext + offset_in;
  assign retire_state = run_en ? StFetch : StIdle;

  assign pc      = pc_q;
  assign illegal = illegal_q;

  cpu_decode u_decode (
    .op_i         (op),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .is_imm_o     (is_imm),
    .is_jump_o    (is_jump),
    .is_illegal_o (is_illegal)
  );

  // Next-state and output decode; every output idles at zero.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    alu_op    = '0;
    alu_b     = '0;
    acc_we    = 1'b0;
    retired   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_en) state_d = StFetch;
      end

      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = StDecode;
        end
      end

      StDecode: begin
        if (is_imm) begin
          acc_we  = 1'b1;
          alu_op  = OpImm;
          alu_b   = imm_ext;
          pc_d    = pc_inc;
          retired = 1'b1;
          state_d = retire_state;
        end else if (is_jump) begin
          pc_d    = (acc_in != '0) ? imm_ext : pc_inc;
          retired = 1'b1;
          state_d = retire_state;
        end else if (is_load || is_store) begin
          state_d = StData;
        end else if (is_illegal) begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end
      end

      StData: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = data_addr;
        mem_wdata = acc_in;
        if (mem_ack) begin
          if (is_store) begin
            pc_d    = pc_inc;
            retired = 1'b1;
            state_d = retire_state;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StExec;
          end
        end
      end

      StExec: begin
        acc_we  = 1'b1;
        alu_op  = op;
        alu_b   = mdr_q;
        pc_d    = pc_inc;
        retired = 1'b1;
        state_d = retire_state;
      end

      // Terminal until reset; PC keeps the faulting address.
      StTrap: begin
        state_d = StTrap;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and architectural registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
